// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: default geometry, depth
// derivation and the threshold legality check used at elaboration.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Depth of a FIFO whose pointers are addr_size bits wide.
`define FIFO_DEPTH(addr_size) (1 << (addr_size))

package fifo_pkg;

    localparam int DEFAULT_DATA_SIZE = 8;
    localparam int DEFAULT_ADDR_SIZE = 2;
    localparam int DEFAULT_AFULL_TH  = 3;
    localparam int DEFAULT_AEMPTY_TH = 1;

    // Accepted-operation decode, encoded as {push_acc, pop_acc}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // True when the almost-full/almost-empty thresholds make sense for the
    // given pointer width: 1 <= afull <= DEPTH and 0 <= aempty <= DEPTH-1.
    function automatic bit thresholds_legal(input int addr_size,
                                            input int afull_th,
                                            input int aempty_th);
        int depth;
        depth = `FIFO_DEPTH(addr_size);
        return (addr_size >= 1) &&
               (afull_th >= 1) && (afull_th <= depth) &&
               (aempty_th >= 0) && (aempty_th <= depth - 1);
    endfunction

endpackage

`endif

// File: rtl/fifo_storage.sv
// DEPTH x DATA_SIZE storage array for fifo_param. Synchronous write,
// registered read port that holds its value between reads, and a full
// synchronous clear of every entry on reset.
module fifo_storage
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    localparam int DEPTH = `FIFO_DEPTH(ADDR_SIZE);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Write port; reset wipes every entry so stale data never leaks out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; a same-edge write to rd_addr returns the old word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO between a switch ingress lane and the
// class-of-service arbiter. Owns pointers, occupancy count, status flags and
// sticky error flags; the word array lives in fifo_storage.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int AFULL_TH  = DEFAULT_AFULL_TH,
    parameter int AEMPTY_TH = DEFAULT_AEMPTY_TH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   fifo_count,
    output logic                 overflow_err,
    output logic                 underflow_err
);

    localparam int DEPTH = `FIFO_DEPTH(ADDR_SIZE);
    localparam logic [ADDR_SIZE:0] DEPTH_CNT  = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AFULL_CNT  = (ADDR_SIZE+1)'(AFULL_TH);
    localparam logic [ADDR_SIZE:0] AEMPTY_CNT = (ADDR_SIZE+1)'(AEMPTY_TH);
    localparam logic [ADDR_SIZE:0] CNT_ONE    = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE  = ADDR_SIZE'(1);

    // Reject instances whose thresholds cannot be reached or are meaningless.
    if (!thresholds_legal(ADDR_SIZE, AFULL_TH, AEMPTY_TH)) begin : g_bad_thresholds
        $error("fifo_param: illegal AFULL_TH/AEMPTY_TH for ADDR_SIZE");
    end

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic                 pop_acc;
    logic                 push_acc;
    fifo_op_e             op;

    // A pop needs data; a push needs room, or a slot being freed this cycle.
    // When empty, a pop is refused even if a push lands (no write-through).
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);

    // Collapse the two accept strobes into a single operation code.
    always_comb begin
        op = OP_IDLE;
        case ({push_acc, pop_acc})
            2'b01:   op = OP_POP;
            2'b10:   op = OP_PUSH;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
    end

    // Pointers advance on accepted operations and wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy is the sole source of full/empty, so pointer equality is never ambiguous.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_count <= '0;
        end else begin
            case (op)
                OP_PUSH: fifo_count <= fifo_count + CNT_ONE;
                OP_POP:  fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // valid_out marks the single cycle in which data_out carries a fresh word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop_acc;
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                overflow_err <= 1'b1;
            end
            if (pop && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

    assign full         = (fifo_count == DEPTH_CNT);
    assign empty        = (fifo_count == '0);
    assign almost_full  = (fifo_count >= AFULL_CNT);
    assign almost_empty = (fifo_count <= AEMPTY_CNT);

    fifo_storage #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_storage (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_acc),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus a randomized
// run, all checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_fifo_param;

    localparam int DATA_SIZE = 8;
    localparam int ADDR_SIZE = 2;
    localparam int DEPTH     = 4;
    localparam int AFULL_TH  = 3;
    localparam int AEMPTY_TH = 1;

    logic                 clk;
    logic                 reset;
    logic                 push;
    logic                 pop;
    logic [DATA_SIZE-1:0] data_in;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDR_SIZE:0]   fifo_count;
    logic                 overflow_err;
    logic                 underflow_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_SIZE-1:0] model_q[$];
    logic [DATA_SIZE-1:0] exp_dout;
    logic                 exp_valid;
    logic                 exp_of;
    logic                 exp_uf;

    fifo_param #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .pop           (pop),
        .data_in       (data_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .fifo_count    (fifo_count),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, update the model from the FIFO rules, then wait past the edge.
    task automatic drive_cycle(input logic p, input logic q,
                               input logic [DATA_SIZE-1:0] d, input logic rst_n);
        int sz;
        bit pop_ok;
        bit push_ok;
        reset   = rst_n;
        push    = p;
        pop     = q;
        data_in = d;
        if (!rst_n) begin
            model_q.delete();
            exp_dout  = '0;
            exp_valid = 1'b0;
            exp_of    = 1'b0;
            exp_uf    = 1'b0;
        end else begin
            sz      = model_q.size();
            pop_ok  = q && (sz > 0);
            push_ok = p && ((sz < DEPTH) || pop_ok);
            if (p && (sz == DEPTH) && !q) exp_of = 1'b1;
            if (q && (sz == 0)) exp_uf = 1'b1;
            exp_valid = pop_ok;
            if (pop_ok) exp_dout = model_q.pop_front();
            if (push_ok) model_q.push_back(d);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b1, 8'hFF, 1'b0);
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_out: got %0h expected 0", data_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid_out); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %0b expected 1", empty); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_aempty: got %0b expected 1", almost_empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %0b expected 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_afull: got %0b expected 0", almost_full); end
        checks++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_errs: got %0b%0b expected 00", overflow_err, underflow_err); end
    endtask

    task automatic test_fill_overflow();
        logic [DATA_SIZE-1:0] d;
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            d = 8'hA1 + 8'(i);
            drive_cycle(1'b1, 1'b0, d, 1'b1);
            checks++; if (fifo_count !== 3'(model_q.size())) begin errors++; $display("[TB] FAIL fill_count%0d: got %0d expected %0d", i, fifo_count, model_q.size()); end
            checks++; if (almost_full !== (i >= 2)) begin errors++; $display("[TB] FAIL fill_afull%0d: got %0b expected %0b", i, almost_full, (i >= 2)); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %0b expected 1", full); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count4: got %0d expected 4", fifo_count); end
        drive_cycle(1'b1, 1'b0, 8'hEE, 1'b1);
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL overflow_flag: got %0b expected 1", overflow_err); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL overflow_count: got %0d expected 4", fifo_count); end
    endtask

    task automatic test_drain_underflow();
        logic [DATA_SIZE-1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'hA1 + 8'(i);
            drive_cycle(1'b0, 1'b1, 8'h00, 1'b1);
            checks++; if (data_out !== d) begin errors++; $display("[TB] FAIL drain_data%0d: got %0h expected %0h", i, data_out, d); end
            checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid%0d: got %0b expected 1", i, valid_out); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %0b expected 1", empty); end
        drive_cycle(1'b0, 1'b1, 8'h00, 1'b1);
        checks++; if (underflow_err !== 1'b1) begin errors++; $display("[TB] FAIL underflow_flag: got %0b expected 1", underflow_err); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL underflow_valid: got %0b expected 0", valid_out); end
        checks++; if (data_out !== 8'hA4) begin errors++; $display("[TB] FAIL underflow_hold: got %0h expected a4", data_out); end
    endtask

    task automatic test_full_push_pop();
        logic [DATA_SIZE-1:0] expect_seq[4];
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 8'hA1 + 8'(i), 1'b1);
        drive_cycle(1'b1, 1'b1, 8'h55, 1'b1);
        checks++; if (data_out !== 8'hA1) begin errors++; $display("[TB] FAIL fullpp_data: got %0h expected a1", data_out); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL fullpp_count: got %0d expected 4", fifo_count); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL fullpp_noovf: got %0b expected 0", overflow_err); end
        expect_seq = '{8'hA2, 8'hA3, 8'hA4, 8'h55};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, 8'h00, 1'b1);
            checks++; if (data_out !== expect_seq[i]) begin errors++; $display("[TB] FAIL fullpp_order%0d: got %0h expected %0h", i, data_out, expect_seq[i]); end
        end
    endtask

    task automatic test_empty_push_pop();
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        drive_cycle(1'b1, 1'b1, 8'h33, 1'b1);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL emptypp_valid: got %0b expected 0", valid_out); end
        checks++; if (underflow_err !== 1'b1) begin errors++; $display("[TB] FAIL emptypp_uf: got %0b expected 1", underflow_err); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL emptypp_count: got %0d expected 1", fifo_count); end
        drive_cycle(1'b0, 1'b1, 8'h00, 1'b1);
        checks++; if (data_out !== 8'h33 || valid_out !== 1'b1) begin errors++; $display("[TB] FAIL emptypp_next: got %0h/%0b expected 33/1", data_out, valid_out); end
    endtask

    task automatic test_wrap();
        logic [DATA_SIZE-1:0] next_out;
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        next_out = 8'h10;
        drive_cycle(1'b1, 1'b0, 8'h10, 1'b1);
        drive_cycle(1'b1, 1'b0, 8'h11, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive_cycle(1'b1, 1'b1, 8'h12 + 8'(i), 1'b1);
            else       drive_cycle(1'b0, 1'b1, 8'h00, 1'b1);
            checks++; if (data_out !== next_out || valid_out !== 1'b1) begin errors++; $display("[TB] FAIL wrap_data%0d: got %0h/%0b expected %0h/1", i, data_out, valid_out, next_out); end
            checks++; if (fifo_count > 3'd2 || fifo_count !== 3'(model_q.size())) begin errors++; $display("[TB] FAIL wrap_count%0d: got %0d expected %0d", i, fifo_count, model_q.size()); end
            next_out = next_out + 8'h01;
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL wrap_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_reset_midstream();
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b1);
        drive_cycle(1'b0, 1'b1, 8'h00, 1'b1);
        drive_cycle(1'b1, 1'b0, 8'hC3, 1'b1);
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("[TB] FAIL mid_precount: got %0d expected 3", fifo_count); end
        drive_cycle(1'b1, 1'b0, 8'h77, 1'b0);
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 0", fifo_count); end
        checks++; if (data_out !== 8'h00 || valid_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_dout: got %0h/%0b expected 0/0", data_out, valid_out); end
        checks++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("[TB] FAIL mid_errs: got %0b%0b expected 00", overflow_err, underflow_err); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (dut.u_storage.mem[i] !== 8'h00) begin errors++; $display("[TB] FAIL mid_mem%0d: got %0h expected 0", i, dut.u_storage.mem[i]); end
        end
    endtask

    task automatic test_random();
        int push_pct;
        logic p, q, r;
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        push_pct = 50;
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 0) push_pct = $urandom_range(15, 85);
            p = ($urandom_range(0, 99) < push_pct);
            q = ($urandom_range(0, 99) >= push_pct);
            if ($urandom_range(0, 3) == 0) q = 1'b1;
            r = ($urandom_range(0, 99) != 0);
            drive_cycle(p, q, 8'($urandom), r);
            checks++; if (data_out !== exp_dout) begin errors++; $display("[TB] FAIL rnd_data@%0d: got %0h expected %0h", i, data_out, exp_dout); end
            checks++; if (valid_out !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid@%0d: got %0b expected %0b", i, valid_out, exp_valid); end
            checks++; if (fifo_count !== 3'(model_q.size())) begin errors++; $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", i, fifo_count, model_q.size()); end
            checks++; if (full !== (model_q.size() == DEPTH)) begin errors++; $display("[TB] FAIL rnd_full@%0d: got %0b", i, full); end
            checks++; if (empty !== (model_q.size() == 0)) begin errors++; $display("[TB] FAIL rnd_empty@%0d: got %0b", i, empty); end
            checks++; if (almost_full !== (model_q.size() >= AFULL_TH)) begin errors++; $display("[TB] FAIL rnd_afull@%0d: got %0b", i, almost_full); end
            checks++; if (almost_empty !== (model_q.size() <= AEMPTY_TH)) begin errors++; $display("[TB] FAIL rnd_aempty@%0d: got %0b", i, almost_empty); end
            checks++; if (overflow_err !== exp_of) begin errors++; $display("[TB] FAIL rnd_ovf@%0d: got %0b expected %0b", i, overflow_err, exp_of); end
            checks++; if (underflow_err !== exp_uf) begin errors++; $display("[TB] FAIL rnd_udf@%0d: got %0b expected %0b", i, underflow_err, exp_uf); end
        end
    endtask

    // Scenario sequence
    initial begin
        reset   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_of    = 1'b0;
        exp_uf    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
